ecu_fetch: RTL
==============

// Module: ecu_fetch
// PURPOSE
//   Byte-serial instruction fetch sequencer feeding the ECU instruction register.
//   Reads the opcode byte, then its operand bytes, one at a time from 8-bit program memory.
//   Packs them into raw/len and pulses we once per complete instruction.
//   Tracks the PC and honours downstream stall and jump redirect (flush).
// PARAMETERS
//   ADDR_W    16  program memory address width; PC wraps modulo 2^ADDR_W
//   RESET_PC  0   PC loaded on reset
// PORTS
//   clk       in   1       clock, rising edge
//   rst       in   1       reset, asynchronous, active-low
//   mem_addr  out  ADDR_W  byte address of current request
//   mem_re    out  1       read request, one-cycle pulse per byte
//   mem_data  in   8       read data, valid when mem_valid=1
//   mem_valid in   1       read response; earliest 1 cycle after mem_re; in-order
//   stall     in   1       downstream not ready; holds ISSUE
//   flush     in   1       redirect; abort current instruction
//   flush_pc  in   ADDR_W  new PC, sampled when flush=1
//   raw       out  32      {d3,d2,d1,opcode}; opcode in [7:0]; unused bytes 0
//   len       out  2       operand byte count 0..3
//   we        out  1       instruction valid pulse to instruction register
//   pc        out  ADDR_W  address of the opcode of the instruction being built
// BEHAVIOUR
//   Reset (rst=0, async): pc=RESET_PC, state=REQ, raw=0, len=0, we=0, mem_re=0,
//     mem_addr=RESET_PC, byte counter=0, drop=0.
//   Length rule: len = opcode[1:0]; instruction occupies len+1 consecutive bytes.
//   FSM states:
//   - REQ: mem_re=1 for exactly one cycle, mem_addr=pc+idx (idx 0=opcode).
//     Next state is WAIT.
//   - WAIT: mem_re=0. On mem_valid, store byte idx into raw[8*idx+:8].
//     On opcode: clear raw[31:8], set len.
//     If idx==len, go to ISSUE; else idx++ and go to REQ.
//     mem_valid is ignored in all other states.
//   - ISSUE, stall=0: we=1 for one cycle, pc<=pc+len+1 (wrapping), idx=0, go to REQ.
//   - ISSUE, stall=1: we=0, stay in ISSUE. raw/len/pc stable.
//   Latency with 1-cycle memory: first mem_re at T0 gives we at T0+2(len+1).
//     One outstanding request maximum.
//   raw/len change only on byte capture and are held after we until the next opcode capture.
//   we is registered, never combinational from stall.
//   Flush (highest priority after reset, any state):
//   - Next cycle: pc=flush_pc, idx=0, we=0, state=REQ.
//   - In ISSUE: we is suppressed even if stall=0. Flush beats stall.
//   - In WAIT without same-cycle mem_valid: set drop. While drop=1, REQ does not
//     assert mem_re. The next mem_valid is discarded and clears drop.
//   - Same-cycle mem_valid and flush: byte discarded, drop not set.
//   Address arithmetic is modulo 2^ADDR_W (0xFFFF+1 -> 0x0000 for ADDR_W=16).
//   Reset mid-operation: all state cleared immediately. A stale response after
//     reset release is not expected; the bench must not deliver one.
// TESTING (1-cycle memory model unless stated)
//   1. Bytes 02,62,60 at 0x0000, release reset -> mem_addr 0,1,2; we at T0+6;
//      raw=0x00606202, len=2; then mem_addr=0x0003.
//   2. Opcode 0xFC -> len=0, raw=0x000000FC, we at T0+2, next pc=pc+1.
//   3. Opcode 0xFF with stall=1 held 5 cycles in ISSUE -> we=0 throughout, raw stable;
//      single we pulse the cycle after stall drops.
//   4. flush_pc=0x0100 asserted during WAIT of operand 1 (3-cycle memory) -> stale byte
//      discarded, no mem_re until it arrives; next mem_addr=0x0100; no we for aborted insn.
//   5. pc=0xFFFE, opcode 0x03 -> mem_addr FFFE,FFFF,0000,0001; next pc=0x0002.
//   6. rst=0 mid-WAIT (between clock edges) -> we, mem_re, raw, len = 0 immediately;
//      after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/ecu_fetch.sv
// Byte-serial instruction fetch sequencer: fetches opcode plus operand bytes from
// 8-bit program memory, packs them into raw/len and pulses we once per instruction.
module ecu_fetch #(
    parameter int unsigned       ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [7:0]        mem_data,
    input  logic              mem_valid,
    input  logic              stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    output logic [31:0]       raw,
    output logic [1:0]        len,
    output logic              we,
    output logic [ADDR_W-1:0] pc
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_ISSUE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [1:0]        idx;
    logic [1:0]        idx_n;
    logic [1:0]        len_n;
    logic [1:0]        cap_len;
    logic [31:0]       raw_n;
    logic [ADDR_W-1:0] pc_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic              we_n;
    logic              mem_re_n;
    logic              drop;
    logic              drop_n;

    // State and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_REQ;
            pc       <= RESET_PC;
            idx      <= 2'd0;
            raw      <= 32'd0;
            len      <= 2'd0;
            we       <= 1'b0;
            mem_re   <= 1'b0;
            mem_addr <= RESET_PC;
            drop     <= 1'b0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            idx      <= idx_n;
            raw      <= raw_n;
            len      <= len_n;
            we       <= we_n;
            mem_re   <= mem_re_n;
            mem_addr <= mem_addr_n;
            drop     <= drop_n;
        end
    end

    // Next-state, capture and issue logic
    always_comb begin
        state_n = state;
        pc_n    = pc;
        idx_n   = idx;
        raw_n   = raw;
        len_n   = len;
        drop_n  = drop;
        we_n    = 1'b0;
        cap_len = (idx == 2'd0) ? mem_data[1:0] : len;

        // The response owed to an aborted request is swallowed here
        if (drop && mem_valid) begin
            drop_n = 1'b0;
        end

        if (flush) begin
            state_n = S_REQ;
            pc_n    = flush_pc;
            idx_n   = 2'd0;
            // A request still in flight must have its response discarded
            if ((state == S_WAIT && !mem_valid) || mem_re) begin
                drop_n = 1'b1;
            end
        end else begin
            unique case (state)
                S_REQ: begin
                    if (mem_re) begin
                        state_n = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_valid && !drop) begin
                        if (idx == 2'd0) begin
                            raw_n = {24'd0, mem_data};
                            len_n = mem_data[1:0];
                        end else begin
                            raw_n[{idx, 3'b000} +: 8] = mem_data;
                        end
                        if (idx == cap_len) begin
                            if (stall) begin
                                state_n = S_ISSUE;
                            end else begin
                                we_n    = 1'b1;
                                pc_n    = pc + ADDR_W'(cap_len) + ADDR_W'(1);
                                idx_n   = 2'd0;
                                state_n = S_REQ;
                            end
                        end else begin
                            idx_n   = idx + 2'd1;
                            state_n = S_REQ;
                        end
                    end
                end
                S_ISSUE: begin
                    if (!stall) begin
                        we_n    = 1'b1;
                        pc_n    = pc + ADDR_W'(len) + ADDR_W'(1);
                        idx_n   = 2'd0;
                        state_n = S_REQ;
                    end
                end
                default: begin
                    state_n = S_REQ;
                end
            endcase
        end

        // Request on the first cycle of every REQ visit unless a stale response is owed
        mem_re_n   = (state_n == S_REQ) && !drop_n && !(state == S_REQ && mem_re && !flush);
        mem_addr_n = pc_n + ADDR_W'(idx_n);
    end

endmodule
